// File: rtl/idelay_sweep_counter.sv
// Multi-channel IDELAY sweep/dwell error counter: steps a shared tap through a range,
// measures per-lane strobe/error counts in a fixed window and streams one record per (tap, lane).
module idelay_sweep_counter #(
  parameter int CHANNELS         = 4,
  parameter int TAP_WIDTH        = 5,
  parameter int COUNT_WIDTH      = 24,
  parameter int HOLDOFF_TIME     = 100,
  parameter int MEASURE_TIME     = 10000,
  parameter int TRIGGER_INTERVAL = 50000000,
  localparam int CH_W            = $clog2((CHANNELS > 2) ? CHANNELS : 2)
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   AUTO,
  input  logic                   START,
  input  logic                   MODE,
  input  logic [TAP_WIDTH-1:0]   TAP_LO,
  input  logic [TAP_WIDTH-1:0]   TAP_HI,
  input  logic [CHANNELS-1:0]    I_STB,
  input  logic [CHANNELS-1:0]    I_ERR,
  output logic                   DLY_LD,
  output logic [TAP_WIDTH-1:0]   DLY_CNT,
  output logic                   BUSY,
  output logic                   O_VALID,
  input  logic                   O_READY,
  output logic [TAP_WIDTH-1:0]   O_TAP,
  output logic [CH_W-1:0]        O_CH,
  output logic [COUNT_WIDTH-1:0] O_ERR,
  output logic [COUNT_WIDTH-1:0] O_SMP,
  output logic                   O_LAST
);

  localparam int TMR_MAX = (HOLDOFF_TIME > MEASURE_TIME) ? HOLDOFF_TIME : MEASURE_TIME;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int IVL_W   = (TRIGGER_INTERVAL > 1) ? $clog2(TRIGGER_INTERVAL) : 1;

  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'((HOLDOFF_TIME > 0) ? HOLDOFF_TIME - 1 : 0);
  localparam logic [TMR_W-1:0] MEAS_LAST = TMR_W'((MEASURE_TIME > 0) ? MEASURE_TIME - 1 : 0);
  localparam logic [IVL_W-1:0] IVL_LAST  = IVL_W'((TRIGGER_INTERVAL > 0) ? TRIGGER_INTERVAL - 1 : 0);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLDOFF,
    S_MEASURE,
    S_DUMP
  } state_t;

  state_t                 state_q, state_d;
  logic [IVL_W-1:0]       ivl_q, ivl_d;
  logic                   ivl_hit;
  logic                   trig;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [TAP_WIDTH-1:0]   tap_q, tap_d;
  logic [TAP_WIDTH-1:0]   end_q, end_d;
  logic [COUNT_WIDTH-1:0] err_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] err_d [CHANNELS];
  logic [COUNT_WIDTH-1:0] smp_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] smp_d [CHANNELS];
  logic                   o_valid_q, o_valid_d;
  logic [TAP_WIDTH-1:0]   o_tap_q, o_tap_d;
  logic [CH_W-1:0]        o_ch_q, o_ch_d;
  logic [COUNT_WIDTH-1:0] o_err_q, o_err_d;
  logic [COUNT_WIDTH-1:0] o_smp_q, o_smp_d;
  logic                   o_last_q, o_last_d;
  logic                   clr_cnt;
  logic                   rec_load;

  always_comb begin
    ivl_hit = AUTO && (ivl_q == IVL_LAST);
    trig    = START || ivl_hit;
    ivl_d   = (AUTO && !ivl_hit) ? ivl_q + 1'b1 : '0;
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    tap_d     = tap_q;
    end_d     = end_q;
    err_d     = err_q;
    smp_d     = smp_q;
    o_valid_d = o_valid_q;
    o_tap_d   = o_tap_q;
    o_ch_d    = o_ch_q;
    o_err_d   = o_err_q;
    o_smp_d   = o_smp_q;
    o_last_d  = o_last_q;
    clr_cnt   = 1'b0;
    rec_load  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          tap_d   = TAP_LO;
          end_d   = (MODE || (TAP_HI < TAP_LO)) ? TAP_LO : TAP_HI;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tmr_d = '0;
        if (HOLDOFF_TIME == 0) begin
          clr_cnt = 1'b1;
          state_d = S_MEASURE;
        end else begin
          state_d = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (tmr_q == HOLD_LAST) begin
          tmr_d   = '0;
          clr_cnt = 1'b1;
          state_d = S_MEASURE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_MEASURE: begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          if (I_STB[c]) begin
            if (smp_d[c] != '1) smp_d[c] = smp_d[c] + 1'b1;
            if (I_ERR[c] && (err_d[c] != '1)) err_d[c] = err_d[c] + 1'b1;
          end
        end
        // The first record is built from err_d/smp_d so the final window sample is included.
        if (tmr_q == MEAS_LAST) begin
          tmr_d    = '0;
          o_ch_d   = '0;
          rec_load = 1'b1;
          state_d  = S_DUMP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_DUMP: begin
        if (O_READY) begin
          if (o_ch_q == CH_LAST) begin
            o_valid_d = 1'b0;
            o_last_d  = 1'b0;
            if (tap_q == end_q) begin
              state_d = S_IDLE;
            end else begin
              tap_d   = tap_q + 1'b1;
              state_d = S_LOAD;
            end
          end else begin
            o_ch_d   = o_ch_q + 1'b1;
            rec_load = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clr_cnt) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        err_d[c] = '0;
        smp_d[c] = '0;
      end
    end

    if (rec_load) begin
      o_valid_d = 1'b1;
      o_tap_d   = tap_q;
      o_err_d   = err_d[o_ch_d];
      o_smp_d   = smp_d[o_ch_d];
      o_last_d  = (tap_q == end_q) && (o_ch_d == CH_LAST);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      ivl_q     <= '0;
      tmr_q     <= '0;
      tap_q     <= '0;
      end_q     <= '0;
      o_valid_q <= 1'b0;
      o_tap_q   <= '0;
      o_ch_q    <= '0;
      o_err_q   <= '0;
      o_smp_q   <= '0;
      o_last_q  <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        err_q[c] <= '0;
        smp_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ivl_q     <= ivl_d;
      tmr_q     <= tmr_d;
      tap_q     <= tap_d;
      end_q     <= end_d;
      o_valid_q <= o_valid_d;
      o_tap_q   <= o_tap_d;
      o_ch_q    <= o_ch_d;
      o_err_q   <= o_err_d;
      o_smp_q   <= o_smp_d;
      o_last_q  <= o_last_d;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        err_q[c] <= err_d[c];
        smp_q[c] <= smp_d[c];
      end
    end
  end

  // tap_q only changes when a LOAD is entered, so it doubles as the held IDELAY value.
  assign DLY_LD  = (state_q == S_LOAD);
  assign DLY_CNT = tap_q;
  assign BUSY    = (state_q != S_IDLE);
  assign O_VALID = o_valid_q;
  assign O_TAP   = o_tap_q;
  assign O_CH    = o_ch_q;
  assign O_ERR   = o_err_q;
  assign O_SMP   = o_smp_q;
  assign O_LAST  = o_last_q;

endmodule

// File: tb/tb_idelay_sweep_counter.sv
// Self-checking bench for idelay_sweep_counter: a transaction-level model tracks run progress
// by tap position and record index and is compared with the DUT on every cycle.
module tb_idelay_sweep_counter;

  localparam int C  = 2;
  localparam int TW = 5;
  localparam int CW = 24;
  localparam int H  = 4;
  localparam int M  = 16;
  localparam int TI = 200;
  localparam longint MAXC = (64'd1 << CW) - 1;

  logic          CLK    = 1'b0;
  logic          RSTN   = 1'b0;
  logic          AUTO   = 1'b0;
  logic          START  = 1'b0;
  logic          MODE   = 1'b0;
  logic [TW-1:0] TAP_LO = '0;
  logic [TW-1:0] TAP_HI = '0;
  logic [C-1:0]  I_STB  = '0;
  logic [C-1:0]  I_ERR  = '0;
  logic          O_READY = 1'b0;
  logic          DLY_LD;
  logic [TW-1:0] DLY_CNT;
  logic          BUSY;
  logic          O_VALID;
  logic [TW-1:0] O_TAP;
  logic [0:0]    O_CH;
  logic [CW-1:0] O_ERR;
  logic [CW-1:0] O_SMP;
  logic          O_LAST;

  always #5 CLK = ~CLK;

  idelay_sweep_counter #(
    .CHANNELS(C), .TAP_WIDTH(TW), .COUNT_WIDTH(CW),
    .HOLDOFF_TIME(H), .MEASURE_TIME(M), .TRIGGER_INTERVAL(TI)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .AUTO(AUTO), .START(START), .MODE(MODE),
    .TAP_LO(TAP_LO), .TAP_HI(TAP_HI), .I_STB(I_STB), .I_ERR(I_ERR),
    .DLY_LD(DLY_LD), .DLY_CNT(DLY_CNT), .BUSY(BUSY), .O_VALID(O_VALID),
    .O_READY(O_READY), .O_TAP(O_TAP), .O_CH(O_CH), .O_ERR(O_ERR),
    .O_SMP(O_SMP), .O_LAST(O_LAST)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit     m_busy = 0;
  int     m_pos  = 0;   // cycles since the tap's load pulse, frozen once records start
  int     m_k    = 0;   // records already accepted for the current tap
  int     m_tap  = 0;
  int     m_end  = 0;
  int     m_dly  = 0;
  int     m_ivl  = 0;
  longint m_err [C];
  longint m_smp [C];

  task automatic model_reset();
    m_busy = 0; m_pos = 0; m_k = 0; m_tap = 0; m_end = 0; m_dly = 0; m_ivl = 0;
    for (int c = 0; c < C; c++) begin m_err[c] = 0; m_smp[c] = 0; end
  endtask

  task automatic model_step();
    bit trig;
    trig  = START || (AUTO && m_ivl == TI - 1);
    m_ivl = (AUTO && m_ivl != TI - 1) ? m_ivl + 1 : 0;
    if (!m_busy) begin
      if (trig) begin
        m_busy = 1; m_pos = 0; m_k = 0;
        m_tap  = int'(TAP_LO);
        m_end  = (MODE || TAP_HI < TAP_LO) ? int'(TAP_LO) : int'(TAP_HI);
        m_dly  = m_tap;
      end
    end else if (m_pos <= H + M) begin
      if (m_pos == H)
        for (int c = 0; c < C; c++) begin m_err[c] = 0; m_smp[c] = 0; end
      if (m_pos > H)
        for (int c = 0; c < C; c++)
          if (I_STB[c]) begin
            if (m_smp[c] < MAXC) m_smp[c]++;
            if (I_ERR[c] && m_err[c] < MAXC) m_err[c]++;
          end
      m_pos++;
    end else if (O_READY) begin
      m_k++;
      if (m_k == C) begin
        if (m_tap == m_end) m_busy = 0;
        else begin m_tap++; m_dly = m_tap; m_pos = 0; m_k = 0; end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RSTN);
      if (!RSTN) model_reset();
      else model_step();
    end
  end

  // ---------------- observation of DUT activity ----------------
  typedef struct { int tap; int ch; longint err; longint smp; int last; } rec_t;
  rec_t recs[$];
  int   ld_val[$];
  int   ld_cyc[$];
  int   cyc = 0, busy_hi = 0, busy_rise = 0, fall_cyc = -1, last_xfer_cyc = -1;
  bit   prev_busy = 0;

  task automatic clear_obs();
    recs.delete(); ld_val.delete(); ld_cyc.delete();
    busy_hi = 0; busy_rise = 0; fall_cyc = -1; last_xfer_cyc = -1;
  endtask

  // per-cycle compare against the model, plus activity logging
  initial begin
    forever begin
      @(negedge CLK);
      if (RSTN) begin
        bit ev;
        ev = m_busy && m_pos > H + M;
        chk("busy", BUSY, m_busy);
        chk("dly_ld", DLY_LD, m_busy && m_pos == 0);
        chk("dly_cnt", DLY_CNT, m_dly);
        chk("o_valid", O_VALID, ev);
        if (ev && O_VALID) begin
          chk("o_tap", O_TAP, m_tap);
          chk("o_ch", O_CH, m_k);
          chk("o_err", O_ERR, m_err[m_k]);
          chk("o_smp", O_SMP, m_smp[m_k]);
          chk("o_last", O_LAST, (m_tap == m_end) && (m_k == C - 1));
        end
        cyc++;
        if (DLY_LD) begin ld_val.push_back(int'(DLY_CNT)); ld_cyc.push_back(cyc); end
        if (BUSY) busy_hi++;
        if (BUSY && !prev_busy) busy_rise++;
        if (!BUSY && prev_busy) fall_cyc = cyc;
        if (O_VALID && O_READY) begin
          recs.push_back('{int'(O_TAP), int'(O_CH), longint'(O_ERR), longint'(O_SMP), int'(O_LAST)});
          last_xfer_cyc = cyc;
        end
      end
      prev_busy = BUSY;
    end
  end

  // ---------------- input driver ----------------
  int stb_mode = 0;   // 0: all strobes, lane0 errors; 1: random; 2: lane0 strobe every 4th cycle
  int rdy_mode = 0;   // 0: always ready; 1: random; 2: held by rdy_hold
  bit rdy_hold = 1;
  int drv_cyc  = 0;

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      drv_cyc++;
      case (stb_mode)
        0: begin I_STB = 2'b11; I_ERR = 2'b01; end
        1: begin I_STB = 2'($urandom); I_ERR = 2'($urandom); end
        default: begin
          I_STB = {1'($urandom), 1'(drv_cyc % 4 == 0)};
          I_ERR = {1'($urandom), 1'b1};
        end
      endcase
      case (rdy_mode)
        0: O_READY = 1'b1;
        1: O_READY = ($urandom_range(0, 3) != 0);
        default: O_READY = rdy_hold;
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_start();
    @(posedge CLK); #1; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (BUSY && n < maxc) begin @(negedge CLK); n++; end
    chk("run_done_in_time", BUSY, 0);
    @(posedge CLK); #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_dly_ld"}, DLY_LD, 0);
    chk({tag, "_dly_cnt"}, DLY_CNT, 0);
    chk({tag, "_o_valid"}, O_VALID, 0);
    chk({tag, "_o_tap"}, O_TAP, 0);
    chk({tag, "_o_ch"}, O_CH, 0);
    chk({tag, "_o_err"}, O_ERR, 0);
    chk({tag, "_o_smp"}, O_SMP, 0);
    chk({tag, "_o_last"}, O_LAST, 0);
  endtask

  task automatic check_single_tap(input string tag, input int tap);
    chk({tag, "_ld_count"}, ld_val.size(), 1);
    if (ld_val.size() > 0) chk({tag, "_ld_tap"}, ld_val[0], tap);
    chk({tag, "_rec_count"}, recs.size(), 2);
    for (int i = 0; i < recs.size() && i < 2; i++) begin
      chk({tag, "_rec_tap"}, recs[i].tap, tap);
      chk({tag, "_rec_ch"}, recs[i].ch, i);
      chk({tag, "_rec_last"}, recs[i].last, (i == 1) ? 1 : 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    #12;
    check_reset_outputs("reset");
    idle_cycles(2);
    #1 RSTN = 1'b1;
    idle_cycles(3);

    // 1: basic sweep 3..5
    clear_obs();
    stb_mode = 0; rdy_mode = 0;
    MODE = 1'b0; TAP_LO = 5'd3; TAP_HI = 5'd5;
    pulse_start();
    wait_idle(500);
    chk("sweep_ld_count", ld_val.size(), 3);
    for (int i = 0; i < ld_val.size() && i < 3; i++) chk("sweep_ld_tap", ld_val[i], 3 + i);
    if (ld_cyc.size() == 3) begin
      chk("sweep_tap_period0", ld_cyc[1] - ld_cyc[0], 1 + H + M + C);
      chk("sweep_tap_period1", ld_cyc[2] - ld_cyc[1], 1 + H + M + C);
    end
    chk("sweep_rec_count", recs.size(), 6);
    for (int i = 0; i < recs.size() && i < 6; i++) begin
      chk("sweep_rec_tap", recs[i].tap, 3 + i / 2);
      chk("sweep_rec_ch", recs[i].ch, i % 2);
      chk("sweep_rec_smp", recs[i].smp, 16);
      chk("sweep_rec_err", recs[i].err, (i % 2 == 0) ? 16 : 0);
      chk("sweep_rec_last", recs[i].last, (i == 5) ? 1 : 0);
    end
    chk("sweep_busy_cycles", busy_hi, 69);
    chk("sweep_busy_fall", fall_cyc - last_xfer_cyc, 1);

    // 2: dwell, then inverted range
    clear_obs();
    MODE = 1'b1; TAP_LO = 5'd7; TAP_HI = 5'd20;
    pulse_start();
    wait_idle(200);
    check_single_tap("dwell", 7);
    clear_obs();
    MODE = 1'b0; TAP_LO = 5'd9; TAP_HI = 5'd2;
    pulse_start();
    wait_idle(200);
    check_single_tap("inverted", 9);

    // 3: strobe qualification
    clear_obs();
    stb_mode = 2;
    MODE = 1'b1; TAP_LO = 5'd1;
    pulse_start();
    wait_idle(200);
    if (recs.size() > 0) begin
      chk("strobe_lane0_smp", recs[0].smp, 4);
      chk("strobe_lane0_err", recs[0].err, 4);
    end else chk("strobe_rec_present", 0, 1);

    // randomized sweeps with random strobes and backpressure
    stb_mode = 1; rdy_mode = 1;
    for (int r = 0; r < 4; r++) begin
      int lo, hi;
      lo = $urandom_range(0, 28);
      hi = lo + $urandom_range(0, 3);
      clear_obs();
      MODE = 1'b0; TAP_LO = 5'(lo); TAP_HI = 5'(hi);
      pulse_start();
      wait_idle(2000);
      chk("random_rec_count", recs.size(), 2 * (hi - lo + 1));
    end

    // 4: backpressure on the first record
    clear_obs();
    rdy_mode = 2; rdy_hold = 1'b0;
    MODE = 1'b0; TAP_LO = 5'd10; TAP_HI = 5'd11;
    pulse_start();
    begin
      int n = 0;
      while (!O_VALID && n < 200) begin @(negedge CLK); n++; end
      chk("stall_valid_seen", O_VALID, 1);
      repeat (10) begin
        @(negedge CLK);
        chk("stall_valid", O_VALID, 1);
        chk("stall_tap", O_TAP, 10);
        chk("stall_ch", O_CH, 0);
        chk("stall_last", O_LAST, 0);
        chk("stall_dly_cnt", DLY_CNT, 10);
      end
      rdy_hold = 1'b1;
    end
    wait_idle(500);
    chk("stall_rec_count", recs.size(), 4);
    for (int i = 0; i < recs.size() && i < 4; i++) begin
      chk("stall_rec_tap", recs[i].tap, 10 + i / 2);
      chk("stall_rec_ch", recs[i].ch, i % 2);
    end
    rdy_mode = 0;

    // 5a: automatic trigger
    clear_obs();
    MODE = 1'b1; TAP_LO = 5'd2;
    AUTO = 1'b1;
    begin
      int n = 0;
      while (n < 300) begin
        @(negedge CLK);
        if (BUSY) break;
        n++;
      end
      chk("auto_trigger_delay", n, TI);
    end
    @(posedge CLK); #1; AUTO = 1'b0;
    wait_idle(200);
    check_single_tap("auto", 2);

    // 5b: START while busy is dropped
    clear_obs();
    MODE = 1'b1; TAP_LO = 5'd4;
    pulse_start();
    idle_cycles(10);
    pulse_start();
    wait_idle(200);
    idle_cycles(30);
    chk("busy_start_runs", busy_rise, 1);
    chk("busy_start_recs", recs.size(), 2);

    // 5c: START in IDLE starts exactly one run
    clear_obs();
    pulse_start();
    wait_idle(200);
    idle_cycles(30);
    chk("idle_start_runs", busy_rise, 1);
    chk("idle_start_recs", recs.size(), 2);

    // 6: asynchronous reset in the middle of a measurement window
    clear_obs();
    MODE = 1'b0; TAP_LO = 5'd5; TAP_HI = 5'd6;
    pulse_start();
    repeat (10) @(posedge CLK);
    #3 RSTN = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    repeat (3) @(posedge CLK);
    #2 RSTN = 1'b1;
    clear_obs();
    idle_cycles(40);
    chk("post_reset_recs", recs.size(), 0);
    chk("post_reset_runs", busy_rise, 0);
    clear_obs();
    pulse_start();
    wait_idle(300);
    chk("post_reset_run_recs", recs.size(), 4);
    chk("post_reset_run_lds", ld_val.size(), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/idelay_sweep_counter.md
Name: idelay_sweep_counter

Overview:
- Multi-channel, parametrised successor to the single-channel IDELAY error counter.
- Steps a shared IDELAY tap setting through a programmable range, or dwells on one tap, and counts per-channel comparator errors and samples in a fixed measurement window.
- Streams one record per (tap, channel) over a valid/ready interface to the message formatter.
- Sits between the per-lane comparators and the UART formatter in the IDELAY histogram design.

Parameters:
- CHANNELS, 4, number of independent comparator lanes
- TAP_WIDTH, 5, width of the IDELAY tap value
- COUNT_WIDTH, 24, width of the error and sample counters
- HOLDOFF_TIME, 100, cycles to wait after a tap load before measuring
- MEASURE_TIME, 10000, cycles in a measurement window
- TRIGGER_INTERVAL, 50000000, cycles between automatic triggers when AUTO=1

Ports:
- CLK  in  1  clock
- RSTN  in  1  asynchronous active-low reset
- AUTO  in  1  1: trigger every TRIGGER_INTERVAL cycles
- START  in  1  single-cycle manual trigger
- MODE  in  1  0: sweep TAP_LO..TAP_HI; 1: dwell on TAP_LO
- TAP_LO  in  TAP_WIDTH  first tap (dwell tap when MODE=1)
- TAP_HI  in  TAP_WIDTH  last tap of the sweep
- I_STB  in  CHANNELS  per-lane sample strobe
- I_ERR  in  CHANNELS  per-lane error flag, qualified by I_STB
- DLY_LD  out  1  IDELAY load pulse
- DLY_CNT  out  TAP_WIDTH  IDELAY tap value
- BUSY  out  1  high from trigger acceptance until the last record is accepted
- O_VALID  out  1  output record valid
- O_READY  in  1  sink ready
- O_TAP  out  TAP_WIDTH  tap of the current record
- O_CH  out  clog2(max(CHANNELS,2))  channel of the current record
- O_ERR  out  COUNT_WIDTH  error count
- O_SMP  out  COUNT_WIDTH  sample count
- O_LAST  out  1  marks the final record of the run

Behaviour:
- Reset (RSTN low, asynchronous): all outputs are 0, FSM enters IDLE, all counters and timers clear.
- Reset takes effect immediately mid-run. A partial run produces no further records.

States: IDLE -> LOAD -> HOLDOFF -> MEASURE -> DUMP -> (LOAD | IDLE)

- Interval timer:
  - Free-running while AUTO=1; held at 0 while AUTO=0.
  - Raises a trigger when it reaches TRIGGER_INTERVAL-1, then wraps to 0.
- Trigger handling:
  - Trigger = START, or the interval expiry.
  - Accepted only in IDLE. A trigger that arrives while BUSY is dropped, not queued.
- On acceptance:
  - MODE, TAP_LO and TAP_HI are latched for the whole run.
  - Effective end tap = TAP_LO if MODE=1 or TAP_HI < TAP_LO; otherwise TAP_HI.
  - Current tap = TAP_LO. BUSY rises the next cycle.
- LOAD (1 cycle):
  - DLY_CNT is driven with the current tap, registered, and stays stable until the next LOAD.
  - DLY_LD is high for exactly this cycle.
- HOLDOFF:
  - Lasts exactly HOLDOFF_TIME cycles. Inputs are ignored.
  - HOLDOFF_TIME=0 skips straight to MEASURE.
- MEASURE:
  - Lasts exactly MEASURE_TIME cycles. Counters are cleared on entry.
  - Each cycle, for each lane c with I_STB[c]=1: sample counter c += 1; error counter c += I_ERR[c].
  - Both counters saturate at 2^COUNT_WIDTH-1.
  - Inputs are sampled on exactly MEASURE_TIME clock edges.
- DUMP:
  - Emits CHANNELS records in order, channel 0 first.
  - Record fields are registered and stable while O_VALID=1 and O_READY=0. No combinational path from O_READY to O_VALID.
  - A record transfers on a cycle with O_VALID & O_READY. The next record may be valid the following cycle, giving 1 record/cycle under continuous ready.
  - O_LAST=1 only on channel CHANNELS-1 of the end tap.
- After the last channel:
  - If current tap == end tap: go to IDLE and drop BUSY the next cycle.
  - Otherwise: tap += 1, go to LOAD.
  - No wrap-around past 2^TAP_WIDTH-1, because the end tap bounds the sweep.
- Latency per tap: 1 + HOLDOFF_TIME + MEASURE_TIME + CHANNELS cycles, plus stall cycles.
- Inputs with I_STB=0 never count, regardless of I_ERR.

Test Plan:
Bench parameters: CHANNELS=2, TAP_WIDTH=5, HOLDOFF_TIME=4, MEASURE_TIME=16, TRIGGER_INTERVAL=200.

1. Basic sweep.
   - Stimulus: MODE=0, TAP_LO=3, TAP_HI=5, START pulse, O_READY=1, I_STB=2'b11 every cycle, lane0 I_ERR=1 always, lane1 I_ERR=0.
   - Required: 3 DLY_LD pulses with DLY_CNT=3,4,5; 6 records, each O_SMP=16; lane0 O_ERR=16, lane1 O_ERR=0; O_LAST only on (tap 5, ch 1).
   - Required: BUSY falls 1 cycle after the last transfer; each tap takes 1+4+16+2 cycles.
2. Dwell and inverted range.
   - Stimulus: MODE=1, TAP_LO=7, TAP_HI=20, START. Repeat with MODE=0, TAP_LO=9, TAP_HI=2.
   - Required: in both cases exactly one tap (7, then 9), 2 records, O_LAST on ch 1.
3. Strobe qualification.
   - Stimulus: lane0 I_STB asserted every 4th cycle with I_ERR=1 constant.
   - Required: lane0 O_SMP=4, O_ERR=4.
4. Backpressure.
   - Stimulus: O_READY low for 10 cycles while the first record is valid, then high.
   - Required: fields held constant during the stall; no record lost or duplicated; DLY_CNT unchanged until the next LOAD.
5. Trigger handling.
   - Stimulus: AUTO=1 with START tied low; separately, a START pulse while BUSY; separately, a START pulse in IDLE.
   - Required: a run begins on the interval expiry at cycle 199 after AUTO rises; the START while BUSY is ignored; the START in IDLE starts exactly one run.
6. Reset mid-MEASURE.
   - Stimulus: drop RSTN asynchronously, hold 3 cycles, release.
   - Required: all outputs are 0 immediately, BUSY=0, no records emitted after release; the next START runs normally.
